// File: rtl/draw_letters_if.sv
// VGA stream bundle shared by the drawing stages.
// Fields: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb (RGB444).
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, rgb
  );
endinterface

// File: rtl/draw_letters.sv
// Overlays font-ROM glyph pixels (TEXT_COLOR) onto the VGA stream,
// with the stream delayed to match ROM latency and optional frame blink.
// Ports: clk, rst (async, active-low), char_addr (ROM address, 0 = none),
//   char_pixels (ROM row, bit 7 leftmost), blink_en,
//   vga_in (previous stage), vga_out (delayed by ROM_LAT+1, overlaid).
module draw_letters #(
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] TEXT_COLOR   = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] char_addr,
  input  logic [7:0]  char_pixels,
  input  logic        blink_en,
  vga_if.in           vga_in,
  vga_if.out          vga_out
);

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t        v;
    logic [10:0] addr;
  } stg_t;

  localparam logic [7:0] BF_LAST = 8'(BLINK_FRAMES - 1);

  stg_t stg_in;
  stg_t stg_d;
  stg_t stg_q [ROM_LAT];

  vga_t out_q;
  vga_t out_d;

  logic       vs_q;
  logic       vs_rise;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       vis_q;
  logic       vis_d;

  logic [2:0] bit_idx;
  logic       pix;
  logic       draw;

  assign stg_in.v.hc  = vga_in.hcount;
  assign stg_in.v.vc  = vga_in.vcount;
  assign stg_in.v.hs  = vga_in.hsync;
  assign stg_in.v.vs  = vga_in.vsync;
  assign stg_in.v.hb  = vga_in.hblnk;
  assign stg_in.v.vb  = vga_in.vblnk;
  assign stg_in.v.rgb = vga_in.rgb;
  assign stg_in.addr  = char_addr;

  // stg_q[k] holds the stream k+1 cycles old.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      stg_q[0] <= stg_in;
      for (int k = 1; k < ROM_LAT; k++) begin
        stg_q[k] <= stg_q[k-1];
      end
    end
  end

  assign stg_d = stg_q[ROM_LAT-1];

  // Leftmost pixel of each 8-pixel cell is glyph bit 7.
  assign bit_idx = 3'd7 - stg_d.v.hc[2:0];
  assign pix     = char_pixels[bit_idx];

  assign draw = pix
              & (stg_d.addr != 11'd0)
              & ~stg_d.v.hb
              & ~stg_d.v.vb
              & vis_q;

  always_comb begin
    out_d = stg_d.v;
    if (draw) begin
      out_d.rgb = TEXT_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign vga_out.hcount = out_q.hc;
  assign vga_out.vcount = out_q.vc;
  assign vga_out.hsync  = out_q.hs;
  assign vga_out.vsync  = out_q.vs;
  assign vga_out.hblnk  = out_q.hb;
  assign vga_out.vblnk  = out_q.vb;
  assign vga_out.rgb    = out_q.rgb;

  // Frame events come from the undelayed vsync.
  assign vs_rise = vga_in.vsync & ~vs_q;

  // Disabling wins over a coincident vsync rise.
  always_comb begin
    cnt_d = cnt_q;
    vis_d = vis_q;
    if (!blink_en) begin
      cnt_d = 8'd0;
      vis_d = 1'b1;
    end else if (vs_rise) begin
      if (cnt_q == BF_LAST) begin
        cnt_d = 8'd0;
        vis_d = ~vis_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q  <= 1'b0;
      cnt_q <= 8'd0;
      vis_q <= 1'b1;
    end else begin
      vs_q  <= vga_in.vsync;
      cnt_q <= cnt_d;
      vis_q <= vis_d;
    end
  end

endmodule
